// File: rtl/stb_pkg.sv
// Shared defaults and state encoding for the sig_gen periodic signal generator.
package stb_pkg;

    localparam int unsigned T_CNT_WIDTH_DEF = 32'd32;
    localparam int unsigned MIN_PERIOD_DEF  = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } sig_gen_state_t;

endpackage

// File: rtl/sig_gen_if.sv
// Configuration handshake bundle for sig_gen: valid/ready plus period and high time.
interface sig_gen_if #(
    parameter int unsigned W = stb_pkg::T_CNT_WIDTH_DEF
);
    logic         cfg_valid_i;
    logic         cfg_ready_o;
    logic [W-1:0] cfg_period_i;
    logic [W-1:0] cfg_high_i;

    modport master (
        output cfg_valid_i,
        output cfg_period_i,
        output cfg_high_i,
        input  cfg_ready_o
    );

    modport slave (
        input  cfg_valid_i,
        input  cfg_period_i,
        input  cfg_high_i,
        output cfg_ready_o
    );
endinterface

// File: rtl/sig_gen_cfg_shadow.sv
// Validates offered configurations and holds one legal pending configuration (shadow).
module sig_gen_cfg_shadow
    import stb_pkg::*;
#(
    parameter int unsigned T_CNT_WIDTH = T_CNT_WIDTH_DEF,
    parameter int unsigned MIN_PERIOD  = MIN_PERIOD_DEF
) (
    input  logic                   clk_i,
    input  logic                   arstn_i,
    sig_gen_if.slave               cfg,
    input  logic                   take_i,
    output logic                   full_o,
    output logic [T_CNT_WIDTH-1:0] period_o,
    output logic [T_CNT_WIDTH-1:0] high_o,
    output logic                   err_o
);

    function automatic logic cfg_legal(input logic [T_CNT_WIDTH-1:0] p,
                                       input logic [T_CNT_WIDTH-1:0] h);
        return (p >= T_CNT_WIDTH'(MIN_PERIOD)) && (h != {T_CNT_WIDTH{1'b0}}) && (h < p);
    endfunction

    logic                   ready_r;
    logic                   full_r;
    logic                   err_r;
    logic [T_CNT_WIDTH-1:0] period_r;
    logic [T_CNT_WIDTH-1:0] high_r;
    logic                   accept_s;
    logic                   legal_s;
    logic                   full_next_s;

    // Handshake decode and next shadow occupancy; accept and take never coincide.
    always_comb begin
        accept_s = cfg.cfg_valid_i & ready_r;
        legal_s  = cfg_legal(cfg.cfg_period_i, cfg.cfg_high_i);
        if (accept_s && legal_s) begin
            full_next_s = 1'b1;
        end else if (take_i) begin
            full_next_s = 1'b0;
        end else begin
            full_next_s = full_r;
        end
    end

    // Shadow storage, sticky error flag and registered ready.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            ready_r  <= 1'b0;
            full_r   <= 1'b0;
            err_r    <= 1'b0;
            period_r <= {T_CNT_WIDTH{1'b0}};
            high_r   <= {T_CNT_WIDTH{1'b0}};
        end else begin
            ready_r <= ~full_next_s;
            full_r  <= full_next_s;
            if (accept_s) begin
                if (legal_s) begin
                    period_r <= cfg.cfg_period_i;
                    high_r   <= cfg.cfg_high_i;
                    err_r    <= 1'b0;
                end else begin
                    err_r    <= 1'b1;
                end
            end
        end
    end

    assign cfg.cfg_ready_o = ready_r;
    assign full_o          = full_r;
    assign period_o        = period_r;
    assign high_o          = high_r;
    assign err_o           = err_r;

endmodule

// File: rtl/sig_gen.sv
// Periodic signal generator: P-cycle period with H cycles high, glitch-free reconfiguration.
// Optional bounded bursts with done pulse when SIG_GEN_BURST_EN is defined.
module sig_gen
    import stb_pkg::*;
#(
    parameter int unsigned T_CNT_WIDTH = T_CNT_WIDTH_DEF,
    parameter int unsigned MIN_PERIOD  = MIN_PERIOD_DEF
) (
    input  logic                   clk_i,
    input  logic                   arstn_i,
    sig_gen_if.slave               cfg,
    input  logic                   en_i,
`ifdef SIG_GEN_BURST_EN
    input  logic [T_CNT_WIDTH-1:0] burst_len_i,
    output logic                   done_o,
`endif
    output logic                   sig_o,
    output logic                   sync_o,
    output logic                   busy_o,
    output logic                   err_o,
    output logic [T_CNT_WIDTH-1:0] edge_cnt_o
);

    localparam logic [T_CNT_WIDTH-1:0] ZERO = {T_CNT_WIDTH{1'b0}};
    localparam logic [T_CNT_WIDTH-1:0] ONE  = T_CNT_WIDTH'(1);

    sig_gen_state_t         state_r;
    logic [T_CNT_WIDTH-1:0] cnt_r;
    logic [T_CNT_WIDTH-1:0] act_period_r;
    logic [T_CNT_WIDTH-1:0] act_low_r;
    logic                   act_valid_r;
    logic                   sig_r;
    logic                   sync_r;
    logic                   busy_r;
    logic [T_CNT_WIDTH-1:0] edge_r;
    logic                   sh_full_s;
    logic [T_CNT_WIDTH-1:0] sh_period_s;
    logic [T_CNT_WIDTH-1:0] sh_high_s;
    logic [T_CNT_WIDTH-1:0] nxt_period_s;
    logic [T_CNT_WIDTH-1:0] nxt_low_s;
    logic                   start_s;
    logic                   period_end_s;
    logic                   take_s;
    logic                   burst_done_s;
`ifdef SIG_GEN_BURST_EN
    logic [T_CNT_WIDTH-1:0] burst_r;
    logic                   done_r;
`endif

    sig_gen_cfg_shadow #(
        .T_CNT_WIDTH (T_CNT_WIDTH),
        .MIN_PERIOD  (MIN_PERIOD)
    ) u_cfg_shadow (
        .clk_i    (clk_i),
        .arstn_i  (arstn_i),
        .cfg      (cfg),
        .take_i   (take_s),
        .full_o   (sh_full_s),
        .period_o (sh_period_s),
        .high_o   (sh_high_s),
        .err_o    (err_o)
    );

    // Parameters for the next period: a pending shadow wins over the active set.
    always_comb begin
        if (sh_full_s) begin
            nxt_period_s = sh_period_s;
            nxt_low_s    = sh_period_s - sh_high_s;
        end else begin
            nxt_period_s = act_period_r;
            nxt_low_s    = act_low_r;
        end
        start_s      = (state_r == IDLE) && en_i && (act_valid_r || sh_full_s);
        period_end_s = (state_r == LOW) && (cnt_r == ZERO);
        take_s       = sh_full_s && (start_s || period_end_s);
`ifdef SIG_GEN_BURST_EN
        burst_done_s = (burst_r != ZERO) && (edge_r == burst_r);
`else
        burst_done_s = 1'b0;
`endif
    end

    // Main FSM; cnt_r runs P-1..0 over the whole period, HIGH ends when it reaches P-H.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_r      <= IDLE;
            cnt_r        <= ZERO;
            act_period_r <= ZERO;
            act_low_r    <= ZERO;
            act_valid_r  <= 1'b0;
            sig_r        <= 1'b0;
            sync_r       <= 1'b0;
            busy_r       <= 1'b0;
            edge_r       <= ZERO;
`ifdef SIG_GEN_BURST_EN
            burst_r      <= ZERO;
            done_r       <= 1'b0;
`endif
        end else begin
            sync_r <= 1'b0;
`ifdef SIG_GEN_BURST_EN
            done_r <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r      <= HIGH;
                        cnt_r        <= nxt_period_s - ONE;
                        act_period_r <= nxt_period_s;
                        act_low_r    <= nxt_low_s;
                        act_valid_r  <= 1'b1;
                        sig_r        <= 1'b1;
                        sync_r       <= 1'b1;
                        busy_r       <= 1'b1;
                        edge_r       <= ONE;
`ifdef SIG_GEN_BURST_EN
                        burst_r      <= burst_len_i;
`endif
                    end else begin
                        sig_r  <= 1'b0;
                        busy_r <= 1'b0;
                    end
                end
                HIGH: begin
                    cnt_r <= cnt_r - ONE;
                    if (cnt_r == act_low_r) begin
                        state_r <= LOW;
                        sig_r   <= 1'b0;
                    end
                end
                LOW: begin
                    if (period_end_s) begin
                        act_period_r <= nxt_period_s;
                        act_low_r    <= nxt_low_s;
                        if (en_i && !burst_done_s) begin
                            state_r <= HIGH;
                            cnt_r   <= nxt_period_s - ONE;
                            sig_r   <= 1'b1;
                            sync_r  <= 1'b1;
                            edge_r  <= edge_r + ONE;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
`ifdef SIG_GEN_BURST_EN
                            done_r  <= burst_done_s;
`endif
                        end
                    end else begin
                        cnt_r <= cnt_r - ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    sig_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign sig_o      = sig_r;
    assign sync_o     = sync_r;
    assign busy_o     = busy_r;
    assign edge_cnt_o = edge_r;
`ifdef SIG_GEN_BURST_EN
    assign done_o     = done_r;
`endif

endmodule
